// File: rtl/fetch_pkg.sv
// Shared constants and entry layout for the instruction prefetch unit.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned ENTRY_W          = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so count
// distinguishes full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + CW'(1);
      if (pop)  rptr <= rptr + CW'(1);
    end
  end

  // Storage is data-only; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;

endmodule

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetcher: credit-limited request stream, in-order
// response queue tagged with PC, redirect flush with stale-response drop.
module ifetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  input  logic        instr_ready
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] pending;
  logic [CW-1:0] drop;
  logic [CW-1:0] occ;
  logic [CW:0]   credit_used;
  logic [31:0]   target;
  logic          req_fire;
  logic          resp_ok;
  logic          push;
  logic          pop;
  fetch_entry_t  wentry;
  fetch_entry_t  hentry;

  assign target      = {redirect_pc[31:2], 2'b00};
  // Every non-dropped pending request already owns a queue slot.
  assign credit_used = {1'b0, occ} + {1'b0, pending} - {1'b0, drop};

  assign imem_req_valid = !reset && !redirect && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_ok = imem_resp_valid && (pending != '0);
  assign push    = resp_ok && (drop == '0) && !redirect;
  assign pop     = instr_valid && instr_ready;

  assign wentry.pc    = resp_pc;
  assign wentry.instr = imem_resp_data;

  assign instr_valid = !reset && (occ != '0);
  assign instr       = instr_valid ? hentry.instr : NOP_INSTR;
  assign pc_out      = instr_valid ? hentry.pc    : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      pending  <= '0;
      drop     <= '0;
    end else begin
      pending <= pending + CW'(req_fire) - CW'(resp_ok);
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= pending - CW'(resp_ok);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     resp_pc  <= resp_pc + 32'd4;
        if (resp_ok && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .head  (hentry),
    .count (occ)
  );

  resp_without_request: assert property (
    @(posedge clk) disable iff (reset) imem_resp_valid |-> (pending != '0)
  );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized bench for ifetch_prefetch against an epoch-tagged transaction model
// with a pipelined, in-order, variable-latency instruction memory.
module tb_ifetch_prefetch;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_ready;

  always #5 clk = ~clk;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .pc_out          (pc_out),
    .instr_ready     (instr_ready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] epoch;
    logic [31:0] due;
  } mreq_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  mreq_t       memq[$];
  ent_t        exq[$];
  logic [31:0] next_addr;
  logic [31:0] epoch;
  logic [31:0] cyc;
  int unsigned mem_lat;
  int unsigned ready_pct;
  int          n_checks;
  int          n_pass;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic rst, input logic rd, input logic [31:0] rpc, input logic ir);
    logic        rv;
    logic        exp_rv;
    logic        acc;
    int unsigned live;
    logic [31:0] due;
    mreq_t       m;
    ent_t        e;

    rv          = (memq.size() != 0) && (memq[0].due <= cyc);
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = ir;
    imem_resp_valid = rv;
    if (rv) imem_resp_data = mem_word(memq[0].addr);
    else    imem_resp_data = 32'hDEAD_BEEF;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    #1;

    live = 0;
    foreach (memq[i]) if (memq[i].epoch == epoch) live++;
    exp_rv = !rst && !rd && ((exq.size() + live) < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, next_addr);

    if (!rst && exq.size() != 0) begin
      check("instr_valid", 32'(instr_valid), 32'd1);
      check("instr", instr, exq[0].word);
      check("pc_out", pc_out, exq[0].pc);
    end else begin
      check("instr_valid", 32'(instr_valid), 32'd0);
      check("instr", instr, NOP);
      check("pc_out", pc_out, 32'h0);
    end
    acc = exp_rv && imem_req_ready;

    @(posedge clk);
    if (rst) begin
      exq.delete();
      memq.delete();
      next_addr = RST_PC;
      epoch++;
    end else begin
      if (ir && exq.size() != 0) void'(exq.pop_front());
      if (rd) exq.delete();
      if (rv) begin
        m = memq.pop_front();
        if (!rd && m.epoch == epoch) begin
          e.pc   = m.addr;
          e.word = mem_word(m.addr);
          exq.push_back(e);
        end
      end
      if (rd) begin
        epoch++;
        next_addr = {rpc[31:2], 2'b00};
      end
      if (acc) begin
        due = cyc + mem_lat;
        if (memq.size() != 0 && memq[$].due >= due) due = memq[$].due + 32'd1;
        m.addr  = next_addr;
        m.epoch = epoch;
        m.due   = due;
        memq.push_back(m);
        next_addr = next_addr + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    int unsigned r;
    logic [31:0] tgt;
    n_checks = 0;
    n_pass   = 0;
    cyc       = 0;
    epoch     = 0;
    next_addr = RST_PC;
    mem_lat   = 1;
    ready_pct = 100;
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b1;
    @(posedge clk);
    #1;

    // Reset release, 1-cycle memory, streaming.
    repeat (2)  step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (30) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Decode stall saturates the queue, then drains in order.
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 3-cycle memory with 3 requests in flight, redirect to unaligned target.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    mem_lat = 3;
    repeat (3)  step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0106, 1'b1);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect coinciding with a response and a head pop.
    mem_lat = 1;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Back-to-back redirects with two requests pending.
    mem_lat = 2;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2)  step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with requests in flight and a partly full queue.
    mem_lat = 3;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // PC wrap-around.
    mem_lat = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int blk = 0; blk < 20; blk++) begin
      mem_lat   = $urandom_range(1, 4);
      ready_pct = $urandom_range(30, 100);
      for (int i = 0; i < 100; i++) begin
        r = $urandom_range(99);
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + ($urandom & 32'h0000_000F);
        else                        tgt = $urandom & 32'h0000_0FFF;
        step(r == 0, (r >= 1) && (r < 7), tgt, $urandom_range(99) < 70);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
